// File: rtl/ex_div_ctrl.sv
// rtl/ex_div_ctrl.sv - iterative restoring divider controller for div.w/mod.w/div.wu/mod.wu
module ex_div_ctrl #(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_req_valid,
    output logic             div_req_ready,
    input  logic             div_signed,
    input  logic             div_is_mod,
    input  logic [DIV_W-1:0] div_src1,
    input  logic [DIV_W-1:0] div_src2,
    input  logic             div_flush,
    output logic             div_res_valid,
    input  logic             div_res_ready,
    output logic [DIV_W-1:0] div_result,
    output logic             div_busy
);

    localparam int CNT_W = $clog2(DIV_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [DIV_W-1:0]   r_quo;
    logic [DIV_W:0]     r_rem;
    logic [DIV_W-1:0]   r_dvs;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_mod;
    logic               r_zero;
    logic [DIV_W-1:0]   r_result;

    logic               w_accept;
    logic               w_last;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [DIV_W-1:0]   w_a_abs;
    logic [DIV_W-1:0]   w_b_abs;
    logic [DIV_W:0]     w_rem_sh;
    logic [DIV_W:0]     w_diff;
    logic               w_qbit;
    logic [DIV_W:0]     w_rem_nx;
    logic [DIV_W-1:0]   w_quo_nx;
    logic [DIV_W-1:0]   w_q_fix;
    logic [DIV_W-1:0]   w_r_fix;

    assign div_req_ready = (r_state == IDLE) & ~reset;
    assign div_res_valid = (r_state == DONE);
    assign div_busy      = (r_state != IDLE);
    assign div_result    = r_result;

    assign w_accept = div_req_valid & div_req_ready & ~div_flush;
    assign w_last   = (r_state == CALC) && (r_cnt == LAST_STEP);

    // The most negative value negates to itself, which is its correct unsigned magnitude.
    assign w_a_neg = div_signed & div_src1[DIV_W-1];
    assign w_b_neg = div_signed & div_src2[DIV_W-1];
    assign w_a_abs = w_a_neg ? -div_src1 : div_src1;
    assign w_b_abs = w_b_neg ? -div_src2 : div_src2;

    // Dividend bits shift out of r_quo's top while quotient bits shift in at the bottom.
    assign w_rem_sh = {r_rem[DIV_W-1:0], r_quo[DIV_W-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvs};
    assign w_qbit   = ~w_diff[DIV_W];
    assign w_rem_nx = w_qbit ? w_diff : w_rem_sh;
    assign w_quo_nx = {r_quo[DIV_W-2:0], w_qbit};

    assign w_q_fix = r_zero  ? {DIV_W{1'b1}} : (r_neg_q ? -w_quo_nx : w_quo_nx);
    assign w_r_fix = r_neg_r ? -w_rem_nx[DIV_W-1:0] : w_rem_nx[DIV_W-1:0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = CALC;
            CALC:    if (w_last) w_next = DONE;
            DONE:    if (div_res_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (div_flush) w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_mod    <= 1'b0;
            r_zero   <= 1'b0;
            r_result <= '0;
        end else if (div_flush) begin
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= '0;
                        r_quo   <= w_a_abs;
                        r_rem   <= '0;
                        r_dvs   <= w_b_abs;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_mod   <= div_is_mod;
                        r_zero  <= (div_src2 == '0);
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_quo <= w_quo_nx;
                    r_rem <= w_rem_nx;
                    if (w_last) begin
                        r_result <= r_mod ? w_r_fix : w_q_fix;
                    end
                end
                DONE: begin
                    if (div_res_ready) r_result <= '0;
                end
                default: r_result <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb/tb_ex_div_ctrl.sv - table-driven and randomized checks of ex_div_ctrl against an arithmetic model
module tb_ex_div_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        div_req_valid;
    logic        div_req_ready;
    logic        div_signed;
    logic        div_is_mod;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        div_flush;
    logic        div_res_valid;
    logic        div_res_ready;
    logic [31:0] div_result;
    logic        div_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ex_div_ctrl #(.DIV_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .div_req_valid (div_req_valid),
        .div_req_ready (div_req_ready),
        .div_signed    (div_signed),
        .div_is_mod    (div_is_mod),
        .div_src1      (div_src1),
        .div_src2      (div_src2),
        .div_flush     (div_flush),
        .div_res_valid (div_res_valid),
        .div_res_ready (div_res_ready),
        .div_result    (div_result),
        .div_busy      (div_busy)
    );

    typedef struct {
        logic        sgn;
        logic        md;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic sgn, input logic md,
                                            input logic [31:0] a, input logic [31:0] b);
        longint la, lb, q, r;
        if (b == 32'd0) return md ? a : 32'hFFFF_FFFF;
        la = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        lb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        q  = la / lb;
        r  = la % lb;
        return md ? r[31:0] : q[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in the current cycle (cycle 0) and step past the accept edge.
    task automatic start_op(input logic sgn, input logic md, input logic [31:0] a, input logic [31:0] b);
        div_req_valid = 1'b1;
        div_signed    = sgn;
        div_is_mod    = md;
        div_src1      = a;
        div_src2      = b;
        check("req_ready_at_accept", {31'd0, div_req_ready}, 32'd1);
        tick();
        div_req_valid = 1'b0;
    endtask

    // Wait in cycles 1.. for valid while scrambling operands; returns the cycle valid appeared.
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!div_res_valid && cyc <= 40) begin
            if (cyc == 16) check("result_zero_in_calc", div_result, 32'd0);
            div_src1   = $urandom;
            div_src2   = $urandom;
            div_signed = 1'($urandom);
            div_is_mod = 1'($urandom);
            tick();
            cyc++;
        end
    endtask

    task automatic consume();
        div_res_ready = 1'b1;
        tick();
        div_res_ready = 1'b0;
    endtask

    task automatic run_op(input logic sgn, input logic md, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input string name);
        int cyc;
        start_op(sgn, md, a, b);
        wait_valid(cyc);
        check({name, "_latency"}, cyc, 32'd33);
        check(name, div_result, exp);
        consume();
        check({name, "_idle_after"}, {30'd0, div_busy, div_res_valid}, 32'd0);
    endtask

    initial begin
        int cyc;
        logic seen;
        logic [31:0] held;
        logic [31:0] ra, rb;
        logic rs, rm;

        tbl[0]  = '{1'b0, 1'b0, 32'd100,         32'd7,          32'd14,         "u_100_div_7"};
        tbl[1]  = '{1'b0, 1'b1, 32'd100,         32'd7,          32'd2,          "u_100_mod_7"};
        tbl[2]  = '{1'b1, 1'b0, 32'hFFFF_FFF9,   32'd2,          32'hFFFF_FFFD,  "s_m7_div_2"};
        tbl[3]  = '{1'b1, 1'b1, 32'hFFFF_FFF9,   32'd2,          32'hFFFF_FFFF,  "s_m7_mod_2"};
        tbl[4]  = '{1'b1, 1'b0, 32'hFFFF_FFF9,   32'hFFFF_FFFE,  32'd3,          "s_m7_div_m2"};
        tbl[5]  = '{1'b1, 1'b0, 32'h8000_0000,   32'hFFFF_FFFF,  32'h8000_0000,  "s_ovf_div"};
        tbl[6]  = '{1'b1, 1'b1, 32'h8000_0000,   32'hFFFF_FFFF,  32'd0,          "s_ovf_mod"};
        tbl[7]  = '{1'b1, 1'b0, 32'h1234_5678,   32'd0,          32'hFFFF_FFFF,  "s_dz_div"};
        tbl[8]  = '{1'b0, 1'b0, 32'h1234_5678,   32'd0,          32'hFFFF_FFFF,  "u_dz_div"};
        tbl[9]  = '{1'b1, 1'b1, 32'h1234_5678,   32'd0,          32'h1234_5678,  "s_dz_mod"};
        tbl[10] = '{1'b0, 1'b1, 32'h1234_5678,   32'd0,          32'h1234_5678,  "u_dz_mod"};

        reset = 1'b1; div_req_valid = 1'b0; div_signed = 1'b0; div_is_mod = 1'b0;
        div_src1 = '0; div_src2 = '0; div_flush = 1'b0; div_res_ready = 1'b0;
        tick();
        tick();
        check("ready_low_in_reset", {31'd0, div_req_ready}, 32'd0);
        check("reset_outputs", {30'd0, div_busy, div_res_valid}, 32'd0);
        check("reset_result", div_result, 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", {31'd0, div_req_ready}, 32'd1);

        for (int i = 0; i < 11; i++)
            run_op(tbl[i].sgn, tbl[i].md, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].name);

        // Backpressure: valid in cycle 33, held through 37, handshake in 38, new accept in 39.
        start_op(1'b0, 1'b0, 32'd1000, 32'd9);
        wait_valid(cyc);
        check("bp_latency", cyc, 32'd33);
        held = div_result;
        check("bp_result", held, 32'd111);
        for (int k = 0; k < 5; k++) begin
            check("bp_stable", div_result, held);
            check("bp_busy_ready", {30'd0, div_busy, div_req_ready}, 32'd2);
            tick();
        end
        check("bp_valid_cycle38", {31'd0, div_res_valid}, 32'd1);
        consume();
        check("bp_idle_cycle39", {30'd0, div_busy, div_req_ready}, 32'd1);
        start_op(1'b0, 1'b0, 32'd5, 32'd5);
        check("bp_new_accept", {31'd0, div_busy}, 32'd1);
        wait_valid(cyc);
        check("bp_new_result", div_result, 32'd1);
        consume();

        // Flush and then reset in cycle 10 of an operation.
        for (int pass = 0; pass < 2; pass++) begin
            start_op(1'b0, 1'b0, 32'd100, 32'd7);
            for (int c = 1; c < 10; c++) tick();
            if (pass == 0) div_flush = 1'b1; else reset = 1'b1;
            tick();
            div_flush = 1'b0;
            reset     = 1'b0;
            #1;
            check(pass == 0 ? "flush_idle" : "reset_idle", {30'd0, div_busy, div_req_ready}, 32'd1);
            check(pass == 0 ? "flush_result" : "reset_result_clr", div_result, 32'd0);
            seen = 1'b0;
            for (int c = 11; c <= 40; c++) begin
                if (div_res_valid) seen = 1'b1;
                tick();
            end
            check(pass == 0 ? "flush_no_valid" : "reset_no_valid", {31'd0, seen}, 32'd0);
            run_op(1'b0, 1'b0, 32'd100, 32'd7, 32'd14, pass == 0 ? "after_flush" : "after_reset");
        end

        // Flush beats a same-cycle request in IDLE.
        div_req_valid = 1'b1; div_flush = 1'b1; div_src1 = 32'd9; div_src2 = 32'd3;
        tick();
        div_req_valid = 1'b0; div_flush = 1'b0;
        #1;
        check("flush_drops_req", {31'd0, div_busy}, 32'd0);
        tick();
        check("flush_drops_req_later", {31'd0, div_busy}, 32'd0);

        // Random operands with corner values mixed in.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = $urandom_range(1, 20);
                3: rb = -$urandom_range(1, 20);
                default: ;
            endcase
            rs = 1'($urandom); rm = 1'($urandom);
            run_op(rs, rm, ra, rb, ref_div(rs, rm, ra, rb), "random");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/ex_div_ctrl.md
EX_DIV_CTRL -- requirements
Module: ex_div_ctrl

Interface
REQ-001 Parameter DIV_W, default 32: operand and result width; the design is verified at 32 only.
REQ-002 clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 reset  in  1  reset; synchronous and active-high.
REQ-004 div_req_valid  in  1  EX holds a div.w/mod.w/div.wu/mod.wu instruction.
REQ-005 div_req_ready  out  1  the controller can accept a request this cycle.
REQ-006 div_signed  in  1  1 = div.w/mod.w; 0 = div.wu/mod.wu.
REQ-007 div_is_mod  in  1  1 = return remainder; 0 = return quotient.
REQ-008 div_src1  in  DIV_W  dividend (rj value).
REQ-009 div_src2  in  DIV_W  divisor (rk value).
REQ-010 div_flush  in  1  cancels any operation in flight (exception or branch kill).
REQ-011 div_res_valid  out  1  div_result holds a completed result.
REQ-012 div_res_ready  in  1  EX consumes the result this cycle.
REQ-013 div_result  out  DIV_W  quotient or remainder.
REQ-014 div_busy  out  1  an operation is accepted and not yet consumed; EX stalls on it.

Function
REQ-015 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-016 Outputs SHALL decode from state as follows:
- div_req_ready = (IDLE & ~reset).
- div_res_valid = DONE.
- div_busy = (state != IDLE).
REQ-017 A request SHALL be accepted when div_req_valid & div_req_ready are both 1 and div_flush is 0; the accept cycle is cycle 0.
REQ-018 On accept, the block SHALL latch:
- |src1| and |src2| (absolute values only when div_signed; 0x80000000 maps to 0x80000000 unsigned);
- the dividend sign, the divisor sign, div_is_mod, and a divisor-zero flag.
REQ-019 On accept, the FSM SHALL go IDLE->CALC and the 5-bit iteration counter SHALL be cleared to 0.
REQ-020 CALC SHALL perform one restoring shift-subtract step per cycle, for 32 steps (counter 0..31), with a 33-bit partial remainder.
REQ-021 When the step at counter==31 completes, the FSM SHALL go CALC->DONE.
REQ-022 div_res_valid SHALL first assert in cycle 33 (fixed latency, independent of operand values).
REQ-023 Sign correction SHALL be applied on entry to DONE:
- quotient is negated when signed & (dividend sign ^ divisor sign);
- remainder is negated when signed & dividend sign.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-025 Divisor zero SHALL give quotient 0xFFFFFFFF and remainder = the original div_src1, for both signed and unsigned, with the same 33-cycle latency.
REQ-026 In DONE, div_result SHALL be registered and stable until div_res_valid & div_res_ready; that handshake SHALL move the FSM DONE->IDLE.
REQ-027 No request SHALL be accepted in the handshake cycle; the earliest next accept is the following cycle.
REQ-028 Changes on div_src1, div_src2, div_signed and div_is_mod after cycle 0 SHALL NOT affect the result.
REQ-029 div_flush=1 in any state SHALL force IDLE on the next edge, with div_res_valid=0 from the next cycle, and no result SHALL be produced for the cancelled operation.
REQ-030 div_flush SHALL take priority over a same-cycle request (the request is dropped) and over a same-cycle result handshake.
REQ-031 div_result SHALL be 0 in IDLE and CALC.

Reset
REQ-032 reset SHALL take priority over div_flush and all handshakes.
REQ-033 While reset is high, div_req_ready SHALL be 0.
REQ-034 After the reset edge, the state SHALL be IDLE, with counter=0, div_res_valid=0, div_busy=0 and div_result=0.
REQ-035 div_req_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-036 reset asserted during CALC or DONE SHALL abandon the operation with no result emitted.

Verification
REQ-037 Unsigned: src1=100, src2=7, signed=0, accept in cycle 0 -> div_res_valid=1 in cycle 33 (not in 32).
- is_mod=0 -> div_result=14.
- is_mod=1 -> div_result=2.
REQ-038 Signed: src1=0xFFFFFFF9 (-7), src2=2.
- div -> 0xFFFFFFFD.
- mod -> 0xFFFFFFFF.
- div with src2=0xFFFFFFFE -> 3.
REQ-039 Overflow and divide-by-zero:
- signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- src1=0x12345678, src2=0, div -> 0xFFFFFFFF, for both signed and unsigned.
- same operands, mod -> 0x12345678.
REQ-040 Backpressure: hold div_res_ready=0 for 5 cycles after valid.
- div_result is stable, div_busy=1 and div_req_ready=0 throughout.
- Handshake in cycle 38 -> IDLE in cycle 39, where a new request is accepted.
REQ-041 Flush and reset:
- div_flush in cycle 10 -> IDLE in cycle 11, no div_res_valid in cycles 33..40.
- A subsequent 100/7 request returns 14.
- Repeat with reset in place of flush: same behaviour.
- div_flush together with a request in IDLE -> request not accepted, div_busy stays 0.
REQ-042 Operand stability: change div_src1 and div_src2 every cycle during CALC -> the result matches the cycle-0 operands.
